// File: rtl/macload_csr_bank_pkg.sv
// Shared definitions for the MAC-load pointer CSR bank.
package macload_csr_bank_pkg;

    localparam logic [1:0] CSR_OP_NONE  = 2'b00;
    localparam logic [1:0] CSR_OP_WRITE = 2'b01;
    localparam logic [1:0] CSR_OP_SET   = 2'b10;
    localparam logic [1:0] CSR_OP_CLEAR = 2'b11;

    localparam logic [11:0] CSR_BASE_DEFAULT = 12'h800;

    typedef enum logic [2:0] {
        RegAAddr     = 3'd0,
        RegWAddr     = 3'd1,
        RegAStride   = 3'd2,
        RegWStride   = 3'd3,
        RegARollback = 3'd4,
        RegWRollback = 3'd5,
        RegASkip     = 3'd6,
        RegWSkip     = 3'd7
    } macload_reg_e;

    localparam int unsigned NumRegs = 8;

    localparam logic [11:0] CSR_A_ADDR     = CSR_BASE_DEFAULT + 12'(RegAAddr);
    localparam logic [11:0] CSR_W_ADDR     = CSR_BASE_DEFAULT + 12'(RegWAddr);
    localparam logic [11:0] CSR_A_STRIDE   = CSR_BASE_DEFAULT + 12'(RegAStride);
    localparam logic [11:0] CSR_W_STRIDE   = CSR_BASE_DEFAULT + 12'(RegWStride);
    localparam logic [11:0] CSR_A_ROLLBACK = CSR_BASE_DEFAULT + 12'(RegARollback);
    localparam logic [11:0] CSR_W_ROLLBACK = CSR_BASE_DEFAULT + 12'(RegWRollback);
    localparam logic [11:0] CSR_A_SKIP     = CSR_BASE_DEFAULT + 12'(RegASkip);
    localparam logic [11:0] CSR_W_SKIP     = CSR_BASE_DEFAULT + 12'(RegWSkip);

endpackage

// File: rtl/macload_csr_bank_reg.sv
// One 32-bit pointer register: software op decode, controller write, software priority.
module macload_csr_bank_reg
    import macload_csr_bank_pkg::*;
#(
    parameter logic [31:0] RstVal = 32'h0
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        sw_hit_i,
    input  logic [1:0]  sw_op_i,
    input  logic [31:0] sw_wdata_i,
    input  logic        mac_we_i,
    input  logic [31:0] mac_wdata_i,
    output logic [31:0] q_o,
    output logic        mac_drop_o
);

    logic [31:0] q_q, q_d;
    logic        sw_commit;

    // Next value: software op wins over a same-cycle controller write.
    always_comb begin
        q_d        = q_q;
        sw_commit  = sw_hit_i && (sw_op_i != CSR_OP_NONE);
        mac_drop_o = sw_commit && mac_we_i;
        if (sw_commit) begin
            case (sw_op_i)
                CSR_OP_WRITE: q_d = sw_wdata_i;
                CSR_OP_SET:   q_d = q_q | sw_wdata_i;
                CSR_OP_CLEAR: q_d = q_q & ~sw_wdata_i;
                default:      q_d = q_q;
            endcase
        end else if (mac_we_i) begin
            q_d = mac_wdata_i;
        end
    end

    // Register state with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            q_q <= RstVal;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/macload_csr_bank.sv
// Activation/weight pointer CSR bank arbitrating software CSR ops and controller updates.
module macload_csr_bank
    import macload_csr_bank_pkg::*;
#(
    parameter logic [11:0] CSR_BASE     = 12'h800,
    parameter logic [31:0] ADDR_RST_VAL = 32'h0
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [1:0]  sw_op_i,
    input  logic [11:0] sw_addr_i,
    input  logic [31:0] sw_wdata_i,
    output logic [31:0] sw_rdata_o,
    output logic        sw_illegal_o,
    input  logic [1:0]  mac_op_i,
    input  logic [11:0] mac_addr_i,
    input  logic [31:0] mac_wdata_i,
    output logic        mac_drop_o,
    output logic [31:0] a_address_o,
    output logic [31:0] w_address_o,
    output logic [31:0] a_stride_o,
    output logic [31:0] w_stride_o,
    output logic [31:0] a_rollback_o,
    output logic [31:0] w_rollback_o,
    output logic [31:0] a_skip_o,
    output logic [31:0] w_skip_o,
    output logic        csr_a_rstn_o,
    output logic        csr_w_rstn_o
);

    logic [NumRegs-1:0] sw_hit;
    logic [NumRegs-1:0] mac_we;
    logic [NumRegs-1:0] drop;
    logic [31:0]        reg_val [NumRegs];
    logic               a_commit, w_commit;
    logic               csr_a_rstn_q, csr_w_rstn_q;

    for (genvar i = 0; i < NumRegs; i++) begin : g_reg
        // Equality against constant addresses; only the two address registers take controller writes.
        assign sw_hit[i] = (sw_addr_i == CSR_BASE + 12'(i));
        if (i < 2) begin : g_mac
            assign mac_we[i] = (mac_op_i == CSR_OP_WRITE) && (mac_addr_i == CSR_BASE + 12'(i));
        end else begin : g_nomac
            assign mac_we[i] = 1'b0;
        end

        macload_csr_bank_reg #(
            .RstVal ((i < 2) ? ADDR_RST_VAL : 32'h0)
        ) u_reg (
            .clk_i       (clk_i),
            .rstn_i      (rstn_i),
            .sw_hit_i    (sw_hit[i]),
            .sw_op_i     (sw_op_i),
            .sw_wdata_i  (sw_wdata_i),
            .mac_we_i    (mac_we[i]),
            .mac_wdata_i (mac_wdata_i),
            .q_o         (reg_val[i]),
            .mac_drop_o  (drop[i])
        );
    end

    // Read mux returns the pre-update value; zero on a miss.
    always_comb begin
        sw_rdata_o = 32'h0;
        for (int i = 0; i < NumRegs; i++) begin
            if (sw_hit[i]) sw_rdata_o = sw_rdata_o | reg_val[i];
        end
    end

    assign sw_illegal_o = (sw_op_i != CSR_OP_NONE) && !(|sw_hit);
    assign mac_drop_o   = |drop;
    assign a_commit     = sw_hit[RegAAddr] && (sw_op_i != CSR_OP_NONE);
    assign w_commit     = sw_hit[RegWAddr] && (sw_op_i != CSR_OP_NONE);

    // Counter-reset strobes: low for the cycle after a software op on an address register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            csr_a_rstn_q <= 1'b1;
            csr_w_rstn_q <= 1'b1;
        end else begin
            csr_a_rstn_q <= !a_commit;
            csr_w_rstn_q <= !w_commit;
        end
    end

    assign csr_a_rstn_o = csr_a_rstn_q;
    assign csr_w_rstn_o = csr_w_rstn_q;

    assign a_address_o  = reg_val[RegAAddr];
    assign w_address_o  = reg_val[RegWAddr];
    assign a_stride_o   = reg_val[RegAStride];
    assign w_stride_o   = reg_val[RegWStride];
    assign a_rollback_o = reg_val[RegARollback];
    assign w_rollback_o = reg_val[RegWRollback];
    assign a_skip_o     = reg_val[RegASkip];
    assign w_skip_o     = reg_val[RegWSkip];

endmodule

// File: tb/tb_macload_csr_bank.sv
// Scoreboard bench for macload_csr_bank.
module tb_macload_csr_bank;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic [1:0]  sw_op_i;
    logic [11:0] sw_addr_i;
    logic [31:0] sw_wdata_i;
    logic [31:0] sw_rdata_o;
    logic        sw_illegal_o;
    logic [1:0]  mac_op_i;
    logic [11:0] mac_addr_i;
    logic [31:0] mac_wdata_i;
    logic        mac_drop_o;
    logic [31:0] a_address_o, w_address_o, a_stride_o, w_stride_o;
    logic [31:0] a_rollback_o, w_rollback_o, a_skip_o, w_skip_o;
    logic        csr_a_rstn_o, csr_w_rstn_o;

    macload_csr_bank u_dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .sw_op_i      (sw_op_i),
        .sw_addr_i    (sw_addr_i),
        .sw_wdata_i   (sw_wdata_i),
        .sw_rdata_o   (sw_rdata_o),
        .sw_illegal_o (sw_illegal_o),
        .mac_op_i     (mac_op_i),
        .mac_addr_i   (mac_addr_i),
        .mac_wdata_i  (mac_wdata_i),
        .mac_drop_o   (mac_drop_o),
        .a_address_o  (a_address_o),
        .w_address_o  (w_address_o),
        .a_stride_o   (a_stride_o),
        .w_stride_o   (w_stride_o),
        .a_rollback_o (a_rollback_o),
        .w_rollback_o (w_rollback_o),
        .a_skip_o     (a_skip_o),
        .w_skip_o     (w_skip_o),
        .csr_a_rstn_o (csr_a_rstn_o),
        .csr_w_rstn_o (csr_w_rstn_o)
    );

    always #5 clk_i = ~clk_i;

    localparam logic [11:0] Base = 12'h800;
    localparam logic [1:0]  OpNone = 2'b00, OpWrite = 2'b01, OpSet = 2'b10, OpClear = 2'b11;

    typedef struct {
        int          idx;
        logic [31:0] val;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] m_reg [8];
    logic        m_arst, m_wrst;
    int          n_checks = 0;
    int          n_errors = 0;

    string names [10] = '{"a_address", "w_address", "a_stride", "w_stride", "a_rollback",
                          "w_rollback", "a_skip", "w_skip", "csr_a_rstn", "csr_w_rstn"};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] dut_out(input int idx);
        case (idx)
            0: return a_address_o;
            1: return w_address_o;
            2: return a_stride_o;
            3: return w_stride_o;
            4: return a_rollback_o;
            5: return w_rollback_o;
            6: return a_skip_o;
            7: return w_skip_o;
            8: return {31'h0, csr_a_rstn_o};
            default: return {31'h0, csr_w_rstn_o};
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = 32'h0;
        m_arst = 1'b1;
        m_wrst = 1'b1;
    endtask

    // One bus cycle: drive, check combinational outputs, predict, then compare after the edge.
    task automatic bus_cycle(input logic [1:0] sop, input logic [11:0] saddr,
                             input logic [31:0] sdata, input logic [1:0] mop,
                             input logic [11:0] maddr, input logic [31:0] mdata);
        int          off;
        bit          hit, commit, mwe;
        logic [31:0] nxt [8];
        exp_t        e;
        @(negedge clk_i);
        sw_op_i = sop; sw_addr_i = saddr; sw_wdata_i = sdata;
        mac_op_i = mop; mac_addr_i = maddr; mac_wdata_i = mdata;
        #1;
        off    = int'(saddr) - int'(Base);
        hit    = (off >= 0) && (off < 8);
        commit = hit && (sop != OpNone);
        mwe    = (mop == OpWrite) && (maddr == Base || maddr == Base + 12'd1);
        check_eq("sw_rdata", sw_rdata_o, hit ? m_reg[off] : 32'h0);
        check_eq("sw_illegal", {31'h0, sw_illegal_o}, {31'h0, (sop != OpNone) && !hit});
        check_eq("mac_drop", {31'h0, mac_drop_o},
                 {31'h0, mwe && commit && (int'(maddr - Base) == off)});
        for (int i = 0; i < 8; i++) nxt[i] = m_reg[i];
        if (mwe) nxt[int'(maddr - Base)] = mdata;
        if (commit) begin
            case (sop)
                OpWrite: nxt[off] = sdata;
                OpSet:   nxt[off] = m_reg[off] | sdata;
                default: nxt[off] = m_reg[off] & ~sdata;
            endcase
        end
        for (int i = 0; i < 8; i++) m_reg[i] = nxt[i];
        m_arst = !(commit && off == 0);
        m_wrst = !(commit && off == 1);
        for (int i = 0; i < 8; i++) begin
            e.idx = i; e.val = m_reg[i]; sb_q.push_back(e);
        end
        e.idx = 8; e.val = {31'h0, m_arst}; sb_q.push_back(e);
        e.idx = 9; e.val = {31'h0, m_wrst}; sb_q.push_back(e);
        @(posedge clk_i);
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq(names[e.idx], dut_out(e.idx), e.val);
        end
    endtask

    initial begin
        rstn_i = 1'b0;
        sw_op_i = OpNone; sw_addr_i = 12'h0; sw_wdata_i = 32'h0;
        mac_op_i = OpNone; mac_addr_i = 12'h0; mac_wdata_i = 32'h0;
        model_reset();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rstn_i = 1'b1;
        #1;
        for (int i = 0; i < 10; i++) check_eq({"rst_", names[i]}, dut_out(i), (i >= 8) ? 32'h1 : 32'h0);
        check_eq("rst_illegal", {31'h0, sw_illegal_o}, 32'h0);
        check_eq("rst_drop", {31'h0, mac_drop_o}, 32'h0);

        // Read every register with op NONE.
        for (int i = 0; i < 8; i++) bus_cycle(OpNone, Base + 12'(i), 32'hffff_ffff, OpNone, 12'h0, 32'h0);

        // WRITE / SET / CLEAR on A_STRIDE.
        bus_cycle(OpWrite, Base + 12'd2, 32'h40, OpNone, 12'h0, 32'h0);
        bus_cycle(OpSet,   Base + 12'd2, 32'h3,  OpNone, 12'h0, 32'h0);
        bus_cycle(OpClear, Base + 12'd2, 32'h1,  OpNone, 12'h0, 32'h0);

        // Address write strobes one cycle only.
        bus_cycle(OpWrite, Base, 32'h1000, OpNone, 12'h0, 32'h0);
        bus_cycle(OpNone,  Base, 32'h0,    OpNone, 12'h0, 32'h0);

        // Same-register collision: software wins, drop flagged.
        bus_cycle(OpWrite, Base + 12'd1, 32'h2000, OpWrite, Base + 12'd1, 32'h2004);
        bus_cycle(OpNone,  12'h0, 32'h0, OpNone, 12'h0, 32'h0);

        // Different registers: both commit, no strobe.
        bus_cycle(OpWrite, Base + 12'd7, 32'h3, OpWrite, Base, 32'h1010);

        // Miss and ignored controller ops.
        bus_cycle(OpWrite, Base + 12'd8, 32'hdead_beef, OpSet, Base, 32'h5555);
        bus_cycle(OpNone,  Base + 12'd8, 32'h0, OpWrite, Base + 12'd2, 32'h7777);
        bus_cycle(OpClear, Base - 12'd1, 32'hffff_ffff, OpNone, 12'h0, 32'h0);

        // Back-to-back software ops on A_ADDR hold the strobe low.
        bus_cycle(OpWrite, Base, 32'h1, OpNone, 12'h0, 32'h0);
        bus_cycle(OpSet,   Base, 32'h2, OpWrite, Base, 32'h9);
        bus_cycle(OpNone,  Base, 32'h0, OpWrite, Base, 32'h9);

        // Random traffic.
        for (int n = 0; n < 60; n++) begin
            bus_cycle(2'($urandom_range(3)), Base + 12'($urandom_range(9)) - 12'd1, $urandom,
                      2'($urandom_range(3)), Base + 12'($urandom_range(3)), $urandom);
        end

        // Asynchronous reset in the middle of a write, while the A strobe is low.
        bus_cycle(OpWrite, Base, 32'h55, OpNone, 12'h0, 32'h0);
        @(negedge clk_i);
        sw_op_i = OpWrite; sw_addr_i = Base; sw_wdata_i = 32'hdead;
        #2;
        rstn_i = 1'b0;
        #1;
        check_eq("midrst_a_address", a_address_o, 32'h0);
        check_eq("midrst_a_rstn", {31'h0, csr_a_rstn_o}, 32'h1);
        @(posedge clk_i);
        #1;
        check_eq("midrst_hold", a_address_o, 32'h0);
        @(negedge clk_i);
        sw_op_i = OpNone;
        rstn_i = 1'b1;
        model_reset();
        bus_cycle(OpNone, Base + 12'd2, 32'h0, OpNone, 12'h0, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
